id_decode_pipe: RTL and testbench
=================================

ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 SHALL have parameter RF_AW, default 5, meaning register address width; register 0 reads as zero.
REQ-003 SHALL have parameter FWD_N, default 3, meaning forwarding sources; index 0 is youngest (EX), FWD_N-1 is oldest (WB).
REQ-004 SHALL have port clk  in  1  as its only clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  in  1  as a synchronous, active-low reset (rst==0 at posedge clk resets).
REQ-006 SHALL have port flush  in  1  to discard the held instruction.
REQ-007 SHALL have ports in_valid  in  1, in_ready  out  1, in_pc  in  XLEN, in_inst  in  32 as the upstream handshake.
REQ-008 SHALL have ports rf_raddr1/rf_raddr2  out  RF_AW, rf_rdata1/rf_rdata2  in  XLEN as the combinational regfile read.
REQ-009 SHALL have ports fwd_we  in  FWD_N, fwd_is_load  in  FWD_N, fwd_waddr  in  FWD_N*RF_AW, fwd_wdata  in  FWD_N*XLEN for the producer buses.
REQ-010 SHALL have ports out_valid  out  1, out_ready  in  1, out_pc  out  XLEN, out_inst  out  32, out_src1/out_src2  out  XLEN as the downstream handshake.
REQ-011 SHALL have ports br_e  out  1, br_addr  out  XLEN, stallreq  out  1.

Function
REQ-012 SHALL hold one instruction slot {valid, pc, inst}; FSM states EMPTY, FULL, HAZ.
REQ-013 SHALL drive in_ready = (state==EMPTY) | (out_valid & out_ready); upstream fire = in_valid & in_ready loads the slot next cycle.
REQ-014 SHALL assert out_valid only in FULL; data stays stable while out_valid & ~out_ready.
REQ-015 SHALL use rs=inst[25:21], rt=inst[20:16]; rs-use and rt-use flags from opcode/func; unused source never causes hazard.
REQ-016 SHALL forward, per source, from the lowest index i with fwd_we[i] & waddr[i]==reg & reg!=0, else rf_rdata.
REQ-017 SHALL enter HAZ when the selected match has fwd_is_load[i]=1; out_valid=0, stallreq=1 in HAZ; re-evaluate each cycle, return to FULL when it clears.
REQ-018 SHALL transition EMPTY->FULL on fire; FULL->EMPTY on downstream fire w/o upstream fire; FULL->FULL on simultaneous fire (slot replaced same edge).
REQ-019 SHALL resolve beq/bne/jal/jr: br_e=1 only on the downstream fire cycle; br_addr = pc+4+(sext(imm16)<<2), {pc+4[31:28],idx26,2'b0}, or src1 for jr.
REQ-020 SHALL, on br_e, drop any same-cycle upstream fire (wrong-path) and go to EMPTY.
REQ-021 SHALL, on flush, go to EMPTY next cycle, ignore same-cycle fires, suppress br_e; flush beats hazard.
REQ-022 SHALL compute pc+4 modulo 2^XLEN (wrap, no carry out).

Reset
REQ-023 SHALL, on rst==0, set state=EMPTY, slot valid/pc/inst=0; hence out_valid=0, br_e=0, stallreq=0, in_ready=1 the following cycle.
REQ-024 SHALL, on reset mid-HAZ or mid-FULL, discard the slot with no br_e emitted.

Configuration
REQ-025 SHALL honour macro ID_FWD_EN: defined -> forwarding per REQ-016/017; undefined -> out_src = rf_rdata only and any fwd_we[i] match on a used source enters HAZ (full interlock).

Verification
REQ-026 SHALL cover: addu r3,r1,r2 with fwd0 we=1 waddr=1 wdata=0x11 and fwd2 waddr=1 wdata=0x22 -> out_src1=0x11.
REQ-027 SHALL cover: lw-producer fwd0 is_load=1 waddr=5, inst uses rs=5 -> stallreq=1, out_valid=0 for 2 cycles, then FULL with forwarded data.
REQ-028 SHALL cover: beq pc=0x100 imm=0x0004, src1==src2, out_ready=1 -> br_e=1 one cycle, br_addr=0x114, same-cycle upstream dropped.
REQ-029 SHALL cover: out_ready=0 for 3 cycles while FULL -> out_pc/out_inst constant, in_ready=0.
REQ-030 SHALL cover: flush and rst==0 each asserted while FULL/HAZ -> next cycle out_valid=0, br_e=0, in_ready=1; without ID_FWD_EN, REQ-026 stimulus -> HAZ.

Source files
------------

// File: rtl/id_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_pipe
// Description : Single-slot instruction-decode pipeline stage. Holds one
//               {pc, inst} entry, reads sources from the register file,
//               optionally forwards from younger producers, detects load-use
//               hazards and resolves beq/bne/jal/jr on the downstream fire.
//               Optional feature macro: ID_FWD_EN
//                 defined   -> operand forwarding, stall only on load-use
//                 undefined -> register-file operands only, full interlock
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5,
    parameter int FWD_N = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_inst,
    output logic [RF_AW-1:0]       rf_raddr1,
    output logic [RF_AW-1:0]       rf_raddr2,
    input  logic [XLEN-1:0]        rf_rdata1,
    input  logic [XLEN-1:0]        rf_rdata2,
    input  logic [FWD_N-1:0]       fwd_we,
    input  logic [FWD_N-1:0]       fwd_is_load,
    input  logic [FWD_N*RF_AW-1:0] fwd_waddr,
    input  logic [FWD_N*XLEN-1:0]  fwd_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_inst,
    output logic [XLEN-1:0]        out_src1,
    output logic [XLEN-1:0]        out_src2,
    output logic                   br_e,
    output logic [XLEN-1:0]        br_addr,
    output logic                   stallreq
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_FULL  = 2'd1;
    localparam logic [1:0] c_HAZ   = 2'd2;

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;
    localparam logic [5:0] c_OP_SB      = 6'h28;
    localparam logic [5:0] c_OP_SH      = 6'h29;
    localparam logic [5:0] c_OP_SW      = 6'h2B;
    localparam logic [5:0] c_FN_SLL     = 6'h00;
    localparam logic [5:0] c_FN_SRL     = 6'h02;
    localparam logic [5:0] c_FN_SRA     = 6'h03;
    localparam logic [5:0] c_FN_JR      = 6'h08;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;

    logic [1:0]      w_state;
    logic [5:0]      w_op;
    logic [5:0]      w_func;
    logic            w_rs_use;
    logic            w_rt_use;
    logic            w_hit1, w_hit2;
    logic            w_ld1, w_ld2;
    logic [XLEN-1:0] w_fd1, w_fd2;
    logic [XLEN-1:0] w_rf1, w_rf2;
    logic [XLEN-1:0] w_src1, w_src2;
    logic            w_haz;
    logic            w_up_fire;
    logic            w_dn_fire;
    logic            w_taken;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_imm_off;
    logic [XLEN-1:0] w_jtarget;

    assign w_op      = r_inst[31:26];
    assign w_func    = r_inst[5:0];
    assign rf_raddr1 = RF_AW'(r_inst[25:21]);
    assign rf_raddr2 = RF_AW'(r_inst[20:16]);

    // Source-usage flags so an operand the instruction ignores never stalls it
    always_comb begin
        w_rs_use = 1'b1;
        w_rt_use = 1'b0;
        case (w_op)
            c_OP_SPECIAL: begin
                if (w_func == c_FN_JR) begin
                    w_rs_use = 1'b1;
                    w_rt_use = 1'b0;
                end else if (w_func == c_FN_SLL || w_func == c_FN_SRL || w_func == c_FN_SRA) begin
                    w_rs_use = 1'b0;
                    w_rt_use = 1'b1;
                end else begin
                    w_rs_use = 1'b1;
                    w_rt_use = 1'b1;
                end
            end
            c_OP_J, c_OP_JAL, c_OP_LUI: begin
                w_rs_use = 1'b0;
                w_rt_use = 1'b0;
            end
            c_OP_BEQ, c_OP_BNE, c_OP_SB, c_OP_SH, c_OP_SW: begin
                w_rs_use = 1'b1;
                w_rt_use = 1'b1;
            end
            default: begin
                w_rs_use = 1'b1;
                w_rt_use = 1'b0;
            end
        endcase
    end

    // Producer match per source; scanning oldest-to-youngest lets the youngest hit win
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_ld1  = 1'b0;
        w_ld2  = 1'b0;
        w_fd1  = '0;
        w_fd2  = '0;
        for (int i = FWD_N - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_waddr[i*RF_AW +: RF_AW] == rf_raddr1) && (rf_raddr1 != '0)) begin
                w_hit1 = 1'b1;
                w_ld1  = fwd_is_load[i];
                w_fd1  = fwd_wdata[i*XLEN +: XLEN];
            end
            if (fwd_we[i] && (fwd_waddr[i*RF_AW +: RF_AW] == rf_raddr2) && (rf_raddr2 != '0)) begin
                w_hit2 = 1'b1;
                w_ld2  = fwd_is_load[i];
                w_fd2  = fwd_wdata[i*XLEN +: XLEN];
            end
        end
    end

    // Register 0 is hard-wired to zero regardless of what the regfile returns
    assign w_rf1 = (rf_raddr1 == '0) ? '0 : rf_rdata1;
    assign w_rf2 = (rf_raddr2 == '0) ? '0 : rf_rdata2;

`ifdef ID_FWD_EN
    assign w_src1 = w_hit1 ? w_fd1 : w_rf1;
    assign w_src2 = w_hit2 ? w_fd2 : w_rf2;
    assign w_haz  = (w_rs_use & w_hit1 & w_ld1) | (w_rt_use & w_hit2 & w_ld2);
`else
    // Without forwarding any in-flight writer of a used source must drain first
    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_ld1, w_ld2, w_fd1, w_fd2};
    assign w_src1 = w_rf1;
    assign w_src2 = w_rf2;
    assign w_haz  = (w_rs_use & w_hit1) | (w_rt_use & w_hit2);
`endif

    // Hazard is re-evaluated every cycle, so the visible state folds it in directly
    assign w_state   = (r_state == c_EMPTY) ? c_EMPTY : (w_haz ? c_HAZ : c_FULL);
    assign out_valid = (w_state == c_FULL);
    assign stallreq  = (w_state == c_HAZ);
    assign in_ready  = (w_state == c_EMPTY) | (out_valid & out_ready);
    assign w_dn_fire = out_valid & out_ready;
    assign w_up_fire = in_valid & in_ready;

    assign out_pc   = r_pc;
    assign out_inst = r_inst;
    assign out_src1 = w_src1;
    assign out_src2 = w_src2;

    assign w_pc4     = r_pc + XLEN'(4);
    assign w_imm_off = {{(XLEN-18){r_inst[15]}}, r_inst[15:0], 2'b00};
    assign w_jtarget = {w_pc4[XLEN-1:28], r_inst[25:0], 2'b00};

    // Branch/jump resolution; target defaults to the conditional-branch form
    always_comb begin
        w_taken = 1'b0;
        br_addr = w_pc4 + w_imm_off;
        case (w_op)
            c_OP_BEQ: w_taken = (w_src1 == w_src2);
            c_OP_BNE: w_taken = (w_src1 != w_src2);
            c_OP_JAL: begin
                w_taken = 1'b1;
                br_addr = w_jtarget;
            end
            c_OP_SPECIAL: begin
                if (w_func == c_FN_JR) begin
                    w_taken = 1'b1;
                    br_addr = w_src1;
                end
            end
            default: w_taken = 1'b0;
        endcase
    end

    // Redirect only when the branch actually leaves the stage; flush and reset cancel it
    assign br_e = w_dn_fire & w_taken & ~flush & rst;

    // Slot FSM: flush/redirect empty the slot and squash any same-cycle upstream fire
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_EMPTY;
            r_pc    <= '0;
            r_inst  <= '0;
        end else if (flush || br_e) begin
            r_state <= c_EMPTY;
        end else if (w_up_fire) begin
            r_state <= c_FULL;
            r_pc    <= in_pc;
            r_inst  <= in_inst;
        end else if (w_dn_fire) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_decode_pipe
// Description : Directed self-checking bench for id_decode_pipe. Expected
//               results follow the ID_FWD_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_decode_pipe;

    localparam int XLEN  = 32;
    localparam int RF_AW = 5;
    localparam int FWD_N = 3;

    localparam logic [31:0] c_ADDU  = 32'h0022_1821; // addu r3,r1,r2
    localparam logic [31:0] c_SUBU  = 32'h0022_2023; // subu r4,r1,r2
    localparam logic [31:0] c_ADDIU = 32'h24A6_0001; // addiu r6,r5,1
    localparam logic [31:0] c_BEQ   = 32'h1022_0004; // beq r1,r2,+4
    localparam logic [31:0] c_BNE   = 32'h1422_0004; // bne r1,r2,+4
    localparam logic [31:0] c_BEQ0  = 32'h1000_0000; // beq r0,r0,0
    localparam logic [31:0] c_JAL   = 32'h0C00_0040; // jal idx=0x40

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [31:0]            in_inst;
    logic [RF_AW-1:0]       rf_raddr1;
    logic [RF_AW-1:0]       rf_raddr2;
    logic [XLEN-1:0]        rf_rdata1;
    logic [XLEN-1:0]        rf_rdata2;
    logic [FWD_N-1:0]       fwd_we;
    logic [FWD_N-1:0]       fwd_is_load;
    logic [FWD_N*RF_AW-1:0] fwd_waddr;
    logic [FWD_N*XLEN-1:0]  fwd_wdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_pc;
    logic [31:0]            out_inst;
    logic [XLEN-1:0]        out_src1;
    logic [XLEN-1:0]        out_src2;
    logic                   br_e;
    logic [XLEN-1:0]        br_addr;
    logic                   stallreq;

    int checks   = 0;
    int failures = 0;

    id_decode_pipe #(
        .XLEN  (XLEN),
        .RF_AW (RF_AW),
        .FWD_N (FWD_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .fwd_we      (fwd_we),
        .fwd_is_load (fwd_is_load),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_src1    (out_src1),
        .out_src2    (out_src2),
        .br_e        (br_e),
        .br_addr     (br_addr),
        .stallreq    (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_fwd(input int i, input logic we, input logic ld,
                           input logic [RF_AW-1:0] addr, input logic [XLEN-1:0] data);
        fwd_we[i]                    = we;
        fwd_is_load[i]               = ld;
        fwd_waddr[i*RF_AW +: RF_AW]  = addr;
        fwd_wdata[i*XLEN +: XLEN]    = data;
    endtask

    // Present one instruction to an empty stage and let it load
    task automatic load(input logic [XLEN-1:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        out_ready = 1'b0; rf_rdata1 = 32'hA1; rf_rdata2 = 32'hB2;
        fwd_we = '0; fwd_is_load = '0; fwd_waddr = '0; fwd_wdata = '0;

        // Reset state
        tick(); tick();
        rst = 1'b1; #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_br_e", br_e, 1'b0);
        check("rst_stallreq", stallreq, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);

        // addu with two producers of r1: youngest (EX) must win
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'h11);
        set_fwd(2, 1'b1, 1'b0, 5'd1, 32'h22);
        load(32'h40, c_ADDU); #1;
`ifdef ID_FWD_EN
        check("fwd_valid", out_valid, 1'b1);
        check("fwd_src1_youngest", out_src1, 32'h11);
        check("fwd_src2_rf", out_src2, 32'hB2);
`else
        check("ilock_stallreq", stallreq, 1'b1);
        check("ilock_out_valid", out_valid, 1'b0);
        check("ilock_in_ready", in_ready, 1'b0);
`endif
        fwd_we = '0; #1;
        check("rf_valid", out_valid, 1'b1);
        check("rf_src1", out_src1, 32'hA1);
        check("rf_src2", out_src2, 32'hB2);
        check("rf_pc", out_pc, 32'h40);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; #1;
        check("drain_valid", out_valid, 1'b0);
        check("drain_in_ready", in_ready, 1'b1);

        // Load-use on rs=r5 for two cycles
        set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h99);
        load(32'h80, c_ADDIU);
        out_ready = 1'b1; #1;
        check("lu1_stallreq", stallreq, 1'b1);
        check("lu1_out_valid", out_valid, 1'b0);
        check("lu1_in_ready", in_ready, 1'b0);
        tick(); #1;
        check("lu2_stallreq", stallreq, 1'b1);
        check("lu2_out_valid", out_valid, 1'b0);
`ifdef ID_FWD_EN
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h55); #1;
        check("lu_rel_src1", out_src1, 32'h55);
`else
        set_fwd(0, 1'b0, 1'b0, 5'd5, 32'h0); #1;
        check("lu_rel_src1", out_src1, 32'hA1);
`endif
        check("lu_rel_valid", out_valid, 1'b1);
        check("lu_rel_stallreq", stallreq, 1'b0);
        check("lu_rel_br_e", br_e, 1'b0);
        tick();
        out_ready = 1'b0; fwd_we = '0; #1;
        check("lu_drain_valid", out_valid, 1'b0);

        // Downstream backpressure for three cycles, then simultaneous fire
        load(32'h200, c_ADDU);
        in_valid = 1'b1; in_pc = 32'h204; in_inst = c_SUBU;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_out_pc", out_pc, 32'h200);
            check("bp_out_inst", out_inst, c_ADDU);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1; #1;
        check("bp_rel_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; #1;
        check("swap_out_pc", out_pc, 32'h204);
        check("swap_out_inst", out_inst, c_SUBU);
        check("swap_out_valid", out_valid, 1'b1);
        tick();
        out_ready = 1'b0; #1;
        check("swap_drain_valid", out_valid, 1'b0);

        // beq taken: one-cycle redirect, wrong-path fetch dropped
        rf_rdata1 = 32'h77; rf_rdata2 = 32'h77;
        load(32'h100, c_BEQ);
        in_valid = 1'b1; in_pc = 32'h104; in_inst = c_ADDU; out_ready = 1'b1; #1;
        check("beq_br_e", br_e, 1'b1);
        check("beq_br_addr", br_addr, 32'h114);
        check("beq_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0; #1;
        check("beq_drop_valid", out_valid, 1'b0);
        check("beq_once_br_e", br_e, 1'b0);
        check("beq_post_in_ready", in_ready, 1'b1);

        // bne with equal sources: not taken
        load(32'h100, c_BNE);
        out_ready = 1'b1; #1;
        check("bne_valid", out_valid, 1'b1);
        check("bne_br_e", br_e, 1'b0);
        tick();
        out_ready = 1'b0;

        // jal target
        load(32'h300, c_JAL);
        out_ready = 1'b1; #1;
        check("jal_br_e", br_e, 1'b1);
        check("jal_br_addr", br_addr, 32'h100);
        tick();
        out_ready = 1'b0;

        // pc+4 wraps to zero
        load(32'hFFFF_FFFC, c_BEQ0);
        out_ready = 1'b1; #1;
        check("wrap_br_e", br_e, 1'b1);
        check("wrap_br_addr", br_addr, 32'h0);
        tick();
        out_ready = 1'b0;

        // Flush while FULL with a taken branch and a same-cycle upstream fire
        load(32'h100, c_BEQ);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h600; in_inst = c_ADDU; #1;
        check("flf_br_e", br_e, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        check("flf_out_valid", out_valid, 1'b0);
        check("flf_in_ready", in_ready, 1'b1);
        check("flf_br_e_after", br_e, 1'b0);

        // Flush while HAZ: producer still asserted afterwards
        set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h99);
        load(32'h80, c_ADDIU); #1;
        check("flh_pre_stallreq", stallreq, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0; #1;
        check("flh_out_valid", out_valid, 1'b0);
        check("flh_stallreq", stallreq, 1'b0);
        check("flh_in_ready", in_ready, 1'b1);
        fwd_we = '0;

        // Reset while FULL with a branch that would fire
        load(32'h100, c_BEQ);
        rst = 1'b0; out_ready = 1'b1; #1;
        check("rsf_br_e", br_e, 1'b0);
        tick();
        rst = 1'b1; out_ready = 1'b0; #1;
        check("rsf_out_valid", out_valid, 1'b0);
        check("rsf_in_ready", in_ready, 1'b1);
        check("rsf_out_pc", out_pc, 32'h0);

        // Reset while HAZ
        set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h99);
        load(32'h80, c_ADDIU);
        rst = 1'b0;
        tick();
        rst = 1'b1; #1;
        check("rsh_stallreq", stallreq, 1'b0);
        check("rsh_out_valid", out_valid, 1'b0);
        check("rsh_in_ready", in_ready, 1'b1);
        fwd_we = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
